// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer for a 64-bit, 1-cycle registered-read instruction memory.
// Ports: clock_i/reset_n_i, stall_i, redirect_i/redirect_pc_i in; imem_addr_o/re_o/ssr_o out,
//   imem_data_i in; valid_o/pc_o/inst0_o/inst1_o out (one instruction pair per cycle to decode).
module imem_fetch_ctrl #(
    parameter int                 ADDR_W     = 10,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter int                 FIFO_DEPTH = 3
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic              imem_re_o,
    output logic              imem_ssr_o,
    input  logic [63:0]       imem_data_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [31:0]       inst0_o,
    output logic [31:0]       inst1_o
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] LAST    = PW'(FIFO_DEPTH - 1);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic {
        ST_FLUSH,
        ST_RUN
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_req_q, pc_req_d;
    logic              infl_q, infl_d;
    logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     rd_q, rd_d;
    logic [PW-1:0]     wr_q, wr_d;
    logic [63:0]       fifo_data_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q   [FIFO_DEPTH];

    logic              run;
    logic              issue;
    logic              push;
    logic              pop;
    logic              valid;
    logic [CW:0]       occ;
    logic [63:0]       head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        state_d   = ST_RUN;
        run       = (state_q == ST_RUN);
        // Occupancy counts the in-flight read so a full FIFO can never overflow.
        occ       = {1'b0, count_q} + {{CW{1'b0}}, infl_q};
        issue     = run & ~redirect_i & (occ < DEPTH_C);
        valid     = (count_q != '0) & ~redirect_i;
        push      = infl_q & ~redirect_i;
        pop       = valid & ~stall_i;
        pc_req_d  = pc_req_q;
        infl_d    = issue;
        infl_pc_d = issue ? pc_req_q : infl_pc_q;
        count_d   = count_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        if (redirect_i) begin
            pc_req_d = {redirect_pc_i[ADDR_W-1:2], 2'b00};
            count_d  = '0;
            rd_d     = '0;
            wr_d     = '0;
        end else begin
            if (issue) begin
                pc_req_d = pc_req_q + ADDR_W'(8);
            end
            if (pop) begin
                rd_d = ptr_inc(rd_q);
            end
            if (push) begin
                wr_d = ptr_inc(wr_q);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_FLUSH;
            pc_req_q  <= RESET_PC;
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
            count_q   <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_req_q  <= pc_req_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
            count_q   <= count_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            if (push) begin
                fifo_data_q[wr_q] <= imem_data_i;
                fifo_pc_q[wr_q]   <= infl_pc_q;
            end
        end
    end

    assign head        = fifo_data_q[rd_q];
    assign imem_addr_o = pc_req_q;
    assign imem_re_o   = issue;
    // The FLUSH cycle and every redirect clear the memory's stale output register.
    assign imem_ssr_o  = ~run | redirect_i;
    assign valid_o     = valid;
    assign pc_o        = fifo_pc_q[rd_q];
    assign inst0_o     = {head[39:32], head[47:40], head[55:48], head[63:56]};
    assign inst1_o     = {head[7:0], head[15:8], head[23:16], head[31:24]};

endmodule
